lightpen_matrix_scan: RTL and testbench

Parametrised scan engine for a ROWS x COLS bicolour (red/green) LED matrix with light-pen hit capture.
- Holds a 2-bit-per-pixel framebuffer and scans it row by row.
- In probe mode it lights one pixel at a time and reports the pixel coordinates at which the light pen fires.
- Sits between the screen state machine (drawing/erasing logic writes the framebuffer and consumes hits) and the matrix pins. It replaces the fixed 8x8 single-mode driver.

---
 rtl/lightpen_matrix_scan_if.sv | 30 +++
 rtl/lightpen_matrix_scan.sv | 198 +++++++++++++++++++
 tb/tb_lightpen_matrix_scan.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lightpen_matrix_scan_if.sv
// Host-side bus of the light-pen matrix scanner: framebuffer writes, clear
// control and pen-hit reporting. The master is the screen state machine; the
// slave is the scan engine.
interface lightpen_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [1:0]    wr_color;
    logic          clear_i;
    logic          clr_busy;
    logic          hit_valid;
    logic [RW-1:0] hit_row;
    logic [CW-1:0] hit_col;

    modport master (
        output wr_en, wr_row, wr_col, wr_color, clear_i,
        input  clr_busy, hit_valid, hit_row, hit_col
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_color, clear_i,
        output clr_busy, hit_valid, hit_row, hit_col
    );
endinterface

// File: rtl/lightpen_matrix_scan.sv
// Scan engine for a ROWS x COLS red/green LED matrix. Holds a 2-bit-per-pixel
// framebuffer, scans it row by row in display mode, and in probe mode lights
// one pixel per sub-slot so a light pen can report which pixel it sees.
//
// Clear sequencer states:
//   state    | meaning
//   ST_IDLE  | framebuffer accepts host writes, clear_i starts a clear
//   ST_CLEAR | zeroing one row per cycle, host writes and clear_i dropped
module lightpen_matrix_scan #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_i,
    input  logic                  pen_i,
    lightpen_matrix_scan_if.slave bus,
    output logic [ROWS-1:0]       row_o,
    output logic [COLS-1:0]       col_r_o,
    output logic [COLS-1:0]       col_g_o,
    output logic                  frame_start
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(DWELL);

    localparam logic [RW:0] ROW_LIM = (RW+1)'(ROWS);
    localparam logic [CW:0] COL_LIM = (CW+1)'(COLS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DW-1:0] dwell;
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    logic          mode_q;

    logic [1:0]    fb [ROWS][COLS];
    logic [0:0]    clr_state;
    logic [RW-1:0] clr_row;

    logic          pen_m;
    logic          pen_s;
    logic          hit_flag;
    logic          hit_valid_q;
    logic [RW-1:0] hit_row_q;
    logic [CW-1:0] hit_col_q;

    logic [COLS-1:0] fb_r_row;
    logic [COLS-1:0] fb_g_row;

    logic dwell_wrap;
    logic c_wrap;
    logic r_wrap;
    logic frame_bound;
    logic mode_eff;
    logic in_blank;
    logic wr_ok;
    logic hit_take;

    assign dwell_wrap  = (dwell == DW'(DWELL - 1));
    assign c_wrap      = (c == CW'(COLS - 1));
    assign r_wrap      = (r == RW'(ROWS - 1));
    assign frame_bound = (r == '0) && (c == '0) && (dwell == '0);
    // The mode register loads on the frame boundary cycle, so the drive for that
    // very cycle already uses the incoming mode and lines up with frame_start.
    assign mode_eff    = frame_bound ? mode_i : mode_q;
    assign in_blank    = (dwell < DW'(BLANK));
    assign wr_ok       = bus.wr_en && !bus.clear_i && (clr_state == ST_IDLE) &&
                         ({1'b0, bus.wr_row} < ROW_LIM) && ({1'b0, bus.wr_col} < COL_LIM);
    assign hit_take    = mode_q && !in_blank && pen_s && !hit_flag;

    assign bus.clr_busy  = (clr_state == ST_CLEAR);
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_row   = hit_row_q;
    assign bus.hit_col   = hit_col_q;

    // Dwell / column / row scan counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
            c     <= '0;
            r     <= '0;
        end else if (dwell_wrap) begin
            dwell <= '0;
            if (c_wrap) begin
                c <= '0;
                r <= r_wrap ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Frame pulse and frame-aligned mode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_bound;
            if (frame_bound) begin
                mode_q <= mode_i;
            end
        end
    end

    // Pick out the current row of the framebuffer as red and green column vectors.
    always_comb begin
        fb_r_row = '0;
        fb_g_row = '0;
        for (int k = 0; k < COLS; k++) begin
            fb_r_row[k] = fb[r][k][0];
            fb_g_row[k] = fb[r][k][1];
        end
    end

    // Registered pin drive; rows are never blanked, only columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_o   <= '1;
            col_r_o <= '0;
            col_g_o <= '0;
        end else begin
            row_o <= ~(ROWS'(1) << r);
            if (mode_eff) begin
                col_r_o <= '0;
                col_g_o <= in_blank ? '0 : (COLS'(1) << c);
            end else if ((c == '0) && in_blank) begin
                col_r_o <= '0;
                col_g_o <= '0;
            end else begin
                col_r_o <= fb_r_row;
                col_g_o <= fb_g_row;
            end
        end
    end

    // Framebuffer storage with host writes and the row-per-cycle clear sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_state <= ST_IDLE;
            clr_row   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                for (int k = 0; k < COLS; k++) begin
                    fb[i][k] <= 2'b00;
                end
            end
        end else begin
            case (clr_state)
                ST_IDLE: begin
                    if (bus.clear_i) begin
                        clr_state <= ST_CLEAR;
                        clr_row   <= '0;
                    end else if (wr_ok) begin
                        fb[bus.wr_row][bus.wr_col] <= bus.wr_color;
                    end
                end
                default: begin
                    for (int k = 0; k < COLS; k++) begin
                        fb[clr_row][k] <= 2'b00;
                    end
                    if (clr_row == RW'(ROWS - 1)) begin
                        clr_state <= ST_IDLE;
                        clr_row   <= '0;
                    end else begin
                        clr_row <= clr_row + 1'b1;
                    end
                end
            endcase
        end
    end

    // Pen synchroniser and one-hit-per-sub-slot capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            pen_m       <= 1'b0;
            pen_s       <= 1'b0;
            hit_flag    <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
        end else begin
            pen_m       <= pen_i;
            pen_s       <= pen_m;
            hit_valid_q <= hit_take;
            hit_flag    <= dwell_wrap ? 1'b0 : (hit_flag | hit_take);
            if (hit_take) begin
                hit_row_q <= r;
                hit_col_q <= c;
            end
        end
    end
endmodule

// File: tb/tb_lightpen_matrix_scan.sv
// Directed bench for lightpen_matrix_scan: pin drive in both modes, mode
// switching at frame boundaries, pen capture and filtering, clear and reset.
module tb_lightpen_matrix_scan;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DWELL = 8;
    localparam int BLANK = 3;
    localparam int FRAME = ROWS * COLS * DWELL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_i = 1'b0;
    logic       pen_i = 1'b0;
    logic [7:0] row_o;
    logic [7:0] col_r_o;
    logic [7:0] col_g_o;
    logic       frame_start;

    lightpen_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus();

    lightpen_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_i(mode_i),
        .pen_i(pen_i),
        .bus(bus),
        .row_o(row_o),
        .col_r_o(col_r_o),
        .col_g_o(col_g_o),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
    } hit_t;

    hit_t exp_q[$];
    int   tpos = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   busy_n;

    // Scan slot whose drive is on the pins after each edge (-1 while in reset).
    always @(posedge clk) tpos <= rst ? -1 : (tpos + 1) % FRAME;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic chk_pins(input string name, input logic [7:0] er, input logic [7:0] ecr,
                            input logic [7:0] ecg);
        chk({name, "_row"}, 32'(row_o), 32'(er));
        chk({name, "_col_r"}, 32'(col_r_o), 32'(ecr));
        chk({name, "_col_g"}, 32'(col_g_o), 32'(ecg));
    endtask

    function automatic int sl(input int r, input int c, input int d);
        return r * COLS * DWELL + c * DWELL + d;
    endfunction

    task automatic goto(input int slot);
        for (int i = 0; i < FRAME + 100; i++) begin
            @(negedge clk);
            if (tpos == slot) return;
        end
        n_chk++;
        $display("FAIL goto_timeout: got no visit, expected slot %0d within a frame", slot);
    endtask

    task automatic wr(input int r, input int c, input logic [1:0] color);
        bus.wr_en    = 1'b1;
        bus.wr_row   = 3'(r);
        bus.wr_col   = 3'(c);
        bus.wr_color = color;
        @(negedge clk);
        bus.wr_en    = 1'b0;
    endtask

    // Monitor: hit reports against the scoreboard, frame_start against the slot model.
    always @(negedge clk) begin
        hit_t e;
        if (!rst && bus.hit_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_hit: got hit row %0d col %0d, expected no hit",
                         bus.hit_row, bus.hit_col);
            end else begin
                e = exp_q.pop_front();
                chk("hit_row", 32'(bus.hit_row), 32'(e.r));
                chk("hit_col", 32'(bus.hit_col), 32'(e.c));
            end
        end
        if (!rst && tpos >= 0 && (frame_start || tpos == 0))
            chk("frame_start", 32'(frame_start), 32'(tpos == 0));
    end

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_row   = '0;
        bus.wr_col   = '0;
        bus.wr_color = 2'b00;
        bus.clear_i  = 1'b0;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_pins("reset", 8'hFF, 8'h00, 8'h00);
        chk("reset_hit_valid", 32'(bus.hit_valid), 32'd0);
        chk("reset_hit_row", 32'(bus.hit_row), 32'd0);
        chk("reset_hit_col", 32'(bus.hit_col), 32'd0);
        chk("reset_clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("reset_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;

        // Frame 0, display mode.
        wr(2, 5, 2'b01);
        wr(2, 6, 2'b11);
        goto(sl(2, 0, 0)); chk_pins("disp_blank0", 8'hFB, 8'h00, 8'h00);
        goto(sl(2, 0, 1)); chk_pins("disp_blank1", 8'hFB, 8'h00, 8'h00);
        goto(sl(2, 0, 2)); chk_pins("disp_blank2", 8'hFB, 8'h00, 8'h00);
        goto(sl(2, 0, 3)); chk_pins("disp_first",  8'hFB, 8'h60, 8'h40);
        goto(sl(2, 3, 1)); chk_pins("disp_noblank", 8'hFB, 8'h60, 8'h40);
        goto(sl(3, 0, 5)); chk_pins("disp_row3",   8'hF7, 8'h00, 8'h00);
        goto(sl(3, 1, 0)); mode_i = 1'b1;
        goto(sl(5, 2, 4)); chk_pins("mode_pending", 8'hDF, 8'h00, 8'h00);
        goto(sl(7, 7, 7)); chk_pins("mode_pending_end", 8'h7F, 8'h00, 8'h00);

        // Frame 1, probe mode.
        goto(sl(0, 0, 0)); chk_pins("probe_start", 8'hFE, 8'h00, 8'h00);
        goto(sl(0, 0, 3)); chk_pins("probe_c0",    8'hFE, 8'h00, 8'h01);
        goto(sl(2, 5, 2)); chk_pins("probe_blank", 8'hFB, 8'h00, 8'h00);
        goto(sl(2, 5, 3)); chk_pins("probe_c5",    8'hFB, 8'h00, 8'h20);
        goto(sl(2, 6, 3)); chk_pins("probe_c6",    8'hFB, 8'h00, 8'h40);

        // Pen held across the whole (4,3) sub-slot: one hit.
        goto(sl(4, 2, 7)); exp_q.push_back('{4, 3}); pen_i = 1'b1;
        goto(sl(4, 3, 7)); pen_i = 1'b0;

        // Pen pulses whose synchronised copy lands only in blank cycles.
        goto(sl(5, 0, 0));
        repeat (3 * COLS * DWELL) begin
            pen_i = ((tpos % DWELL) >= 5);
            @(negedge clk);
        end
        pen_i = 1'b0;

        // Frame 2: single-cycle pen seen at dwell 5 of (4,3).
        goto(sl(4, 3, 4)); exp_q.push_back('{4, 3}); pen_i = 1'b1;
        @(negedge clk); pen_i = 1'b0;
        goto(sl(6, 0, 0)); mode_i = 1'b0;
        goto(sl(7, 0, 0));
        chk("hit_row_held", 32'(bus.hit_row), 32'd4);
        chk("hit_col_held", 32'(bus.hit_col), 32'd3);

        // Frame 3, display mode again: continuous pen is ignored.
        goto(sl(0, 1, 0)); pen_i = 1'b1;
        goto(sl(2, 0, 0)); pen_i = 1'b0;
        goto(sl(2, 6, 3)); chk_pins("disp_again", 8'hFB, 8'h60, 8'h40);

        // Fill with 11, then clear.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr(r, c, 2'b11);
        goto(sl(5, 1, 3)); chk_pins("filled", 8'hDF, 8'hFF, 8'hFF);

        bus.clear_i  = 1'b1;
        bus.wr_en    = 1'b1;
        bus.wr_row   = 3'd1;
        bus.wr_col   = 3'd1;
        bus.wr_color = 2'b01;
        @(negedge clk);
        bus.clear_i = 1'b0;
        bus.wr_en   = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20 && bus.clr_busy; i++) begin
            busy_n++;
            if (busy_n == 3) begin
                bus.clear_i  = 1'b1;
                bus.wr_en    = 1'b1;
                bus.wr_row   = 3'd0;
                bus.wr_col   = 3'd2;
                bus.wr_color = 2'b10;
            end else begin
                bus.clear_i = 1'b0;
                bus.wr_en   = 1'b0;
            end
            @(negedge clk);
        end
        bus.clear_i = 1'b0;
        bus.wr_en   = 1'b0;
        chk("clr_busy_cycles", 32'(busy_n), 32'd8);
        for (int r = 0; r < ROWS; r++) begin
            goto(sl(r, 2, 0));
            chk("cleared_row", {16'h0, col_r_o, col_g_o}, 32'd0);
        end

        // Reset in the third clear cycle.
        wr(3, 3, 2'b11);
        bus.clear_i = 1'b1;
        @(negedge clk); bus.clear_i = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("rst_hit_row", 32'(bus.hit_row), 32'd0);
        chk("rst_hit_col", 32'(bus.hit_col), 32'd0);
        chk_pins("rst_mid", 8'hFF, 8'h00, 8'h00);
        rst = 1'b0;
        goto(sl(3, 3, 0)); chk_pins("rst_fb_zero", 8'hF7, 8'h00, 8'h00);

        repeat (20) @(negedge clk);
        chk("hits_pending", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
